// File: rtl/instr_fetch_pkg.sv
// Shared CPU definitions for the fetch stage: NOP encoding, default reset PC,
// fetch FSM state encoding.
package instr_fetch_pkg;

  localparam logic [31:0] NOP              = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int          INSTR_BYTES      = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    KILL = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_if_id_reg.sv
// IF/ID pipeline register: flush forces a NOP bubble, stall freezes contents,
// an empty slot with no stall drains to a bubble.
module if_id_reg
  import instr_fetch_pkg::*;
#(
  parameter int BITS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            stall_i,
  input  logic            load_i,
  input  logic [BITS-1:0] pc_i,
  input  logic [BITS-1:0] instr_i,
  output logic            valid_o,
  output logic [BITS-1:0] pc_o,
  output logic [BITS-1:0] instr_o
);

  logic            valid_q;
  logic [BITS-1:0] pc_q;
  logic [BITS-1:0] instr_q;

  // Load wins over stall so that a bubble sitting in IF/ID never blocks fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= BITS'(NOP);
    end else if (flush_i) begin
      valid_q <= 1'b0;
      instr_q <= BITS'(NOP);
    end else if (load_i) begin
      valid_q <= 1'b1;
      pc_q    <= pc_i;
      instr_q <= instr_i;
    end else if (!stall_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign instr_o = instr_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: single-outstanding imem requests, one-entry skid
// buffer for decode back-pressure, redirect with kill of in-flight data.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          BITS     = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [BITS-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [BITS-1:0] imem_rdata,
  input  logic            stall,
  input  logic            redirect,
  input  logic [BITS-1:0] redirect_pc,
  output logic            if_id_valid,
  output logic [BITS-1:0] if_id_pc,
  output logic [BITS-1:0] if_id_instr,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7
);

  fetch_state_e    state_q;
  logic            imem_req_q;
  logic [BITS-1:0] pc_q;
  logic [BITS-1:0] tgt_q;
  logic            skid_valid_q;
  logic [BITS-1:0] skid_pc_q;
  logic [BITS-1:0] skid_instr_q;

  logic            redirect_flush;
  logic [BITS-1:0] redirect_tgt;
  logic [BITS-1:0] pc_next;
  logic            fetch_load;
  logic            skid_load;
  logic            ifid_load_d;
  logic [BITS-1:0] ifid_pc_d;
  logic [BITS-1:0] ifid_instr_d;

  assign redirect_flush = redirect;
  assign redirect_tgt   = redirect_pc & ~BITS'(INSTR_BYTES - 1);
  assign pc_next        = pc_q + BITS'(INSTR_BYTES);

  // Returning data goes straight to IF/ID unless decode is stalled on a live word.
  assign fetch_load   = (state_q == REQ) && imem_ack && !redirect &&
                        (!stall || !if_id_valid);
  assign skid_load    = (state_q == HOLD) && skid_valid_q && !stall && !redirect;
  assign ifid_load_d  = fetch_load || skid_load;
  assign ifid_pc_d    = skid_load ? skid_pc_q    : pc_q;
  assign ifid_instr_d = skid_load ? skid_instr_q : imem_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      imem_req_q   <= 1'b0;
      pc_q         <= BITS'(RESET_PC);
      tgt_q        <= '0;
      skid_valid_q <= 1'b0;
      skid_pc_q    <= '0;
      skid_instr_q <= BITS'(NOP);
    end else begin
      if (redirect) begin
        skid_valid_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          state_q    <= REQ;
          imem_req_q <= 1'b1;
          if (redirect) begin
            pc_q <= redirect_tgt;
          end
        end
        REQ: begin
          if (redirect) begin
            if (imem_ack) begin
              pc_q <= redirect_tgt;
            end else begin
              tgt_q   <= redirect_tgt;
              state_q <= KILL;
            end
          end else if (imem_ack) begin
            pc_q <= pc_next;
            if (stall && if_id_valid) begin
              skid_valid_q <= 1'b1;
              skid_pc_q    <= pc_q;
              skid_instr_q <= imem_rdata;
              imem_req_q   <= 1'b0;
              state_q      <= HOLD;
            end
          end
        end
        HOLD: begin
          if (redirect) begin
            pc_q       <= redirect_tgt;
            imem_req_q <= 1'b1;
            state_q    <= REQ;
          end else if (!stall) begin
            skid_valid_q <= 1'b0;
            imem_req_q   <= 1'b1;
            state_q      <= REQ;
          end
        end
        KILL: begin
          // The old request must complete on its own address; its data is dropped.
          if (imem_ack) begin
            pc_q    <= redirect ? redirect_tgt : tgt_q;
            state_q <= REQ;
          end else if (redirect) begin
            tgt_q <= redirect_tgt;
          end
        end
        default: begin
          state_q    <= IDLE;
          imem_req_q <= 1'b0;
        end
      endcase
    end
  end

  if_id_reg #(
    .BITS(BITS)
  ) u_if_id_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (redirect_flush),
    .stall_i (stall),
    .load_i  (ifid_load_d),
    .pc_i    (ifid_pc_d),
    .instr_i (ifid_instr_d),
    .valid_o (if_id_valid),
    .pc_o    (if_id_pc),
    .instr_o (if_id_instr)
  );

  assign imem_req  = imem_req_q;
  assign imem_addr = pc_q;
  assign opcode    = if_id_instr[6:0];
  assign funct3    = if_id_instr[14:12];
  assign funct7    = if_id_instr[31:25];

endmodule
